rf_write_queue: RTL and testbench

- Writer-side companion to the pipeline register file. Accepts register write requests from the writeback stage over a valid/ready handshake and buffers them in a small FIFO.
- Drains one entry per cycle onto the register file's single write port (wrt_en/dest/data). The register file commits on the falling edge of the same cycle.
- Provides a two-port read bypass so decode sees queued, not-yet-committed values.

---
 rtl/rf_write_queue.sv | 101 ++++++++++
 tb/tb_rf_write_queue.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_queue.sv
// Register-file write queue: buffers writeback requests in a small circular FIFO,
// drains one per cycle onto the register file write port, and bypasses queued data to decode.
module rf_write_queue #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned DEPTH         = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_valid,
  output logic                       wb_ready,
  input  logic [ADDRESS_WIDTH-1:0]   wb_dest,
  input  logic [DATA_WIDTH-1:0]      wb_data,
  input  logic                       port_busy,
  output logic                       rg_wrt_en,
  output logic [ADDRESS_WIDTH-1:0]   rg_wrt_dest,
  output logic [DATA_WIDTH-1:0]      rg_wrt_data,
  input  logic [ADDRESS_WIDTH-1:0]   byp_addr1,
  input  logic [ADDRESS_WIDTH-1:0]   byp_addr2,
  output logic                       byp_hit1,
  output logic [DATA_WIDTH-1:0]      byp_data1,
  output logic                       byp_hit2,
  output logic [DATA_WIDTH-1:0]      byp_data2,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]         r_head;
  logic [PTR_W-1:0]         r_tail;
  logic [CNT_W-1:0]         r_count;
  logic [DEPTH-1:0]         r_vld;
  logic [ADDRESS_WIDTH-1:0] r_dest [DEPTH];
  logic [DATA_WIDTH-1:0]    r_data [DEPTH];

  logic                     w_empty;
  logic                     w_push;
  logic                     w_pop;
  logic [PTR_W-1:0]         w_idx;

  assign w_empty  = (r_count == '0);
  assign wb_ready = (r_count < CNT_W'(DEPTH));
  // Writes to r0 complete the handshake but are never stored.
  assign w_push   = wb_valid && wb_ready && (wb_dest != '0);
  assign w_pop    = !w_empty && !port_busy;

  assign rg_wrt_en   = w_pop;
  assign rg_wrt_dest = w_empty ? '0 : r_dest[r_head];
  assign rg_wrt_data = w_empty ? '0 : r_data[r_head];
  assign count       = r_count;

  // Pointer, occupancy and entry-valid state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      if (w_push) begin
        r_tail        <= r_tail + PTR_W'(1);
        r_vld[r_tail] <= 1'b1;
      end
      if (w_pop) begin
        r_head        <= r_head + PTR_W'(1);
        r_vld[r_head] <= 1'b0;
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Entry payload storage; validity is tracked separately so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_dest[r_tail] <= wb_dest;
      r_data[r_tail] <= wb_data;
    end
  end

  // Walk oldest to youngest so the youngest match wins; draining head still counts.
  always_comb begin
    byp_hit1  = 1'b0;
    byp_data1 = '0;
    byp_hit2  = 1'b0;
    byp_data2 = '0;
    w_idx     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PTR_W'(i);
      if (r_vld[w_idx] && (byp_addr1 != '0) && (r_dest[w_idx] == byp_addr1)) begin
        byp_hit1  = 1'b1;
        byp_data1 = r_data[w_idx];
      end
      if (r_vld[w_idx] && (byp_addr2 != '0) && (r_dest[w_idx] == byp_addr2)) begin
        byp_hit2  = 1'b1;
        byp_data2 = r_data[w_idx];
      end
    end
  end

endmodule

// File: tb/tb_rf_write_queue.sv
// Directed bench for rf_write_queue with a falling-edge register file model and drain log.
module tb_rf_write_queue;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        port_busy;
  logic        rg_wrt_en;
  logic [4:0]  rg_wrt_dest;
  logic [31:0] rg_wrt_data;
  logic [4:0]  byp_addr1;
  logic [4:0]  byp_addr2;
  logic        byp_hit1;
  logic [31:0] byp_data1;
  logic        byp_hit2;
  logic [31:0] byp_data2;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  logic [31:0] rf [32];
  logic [4:0]  log_dest [$];
  logic [31:0] log_data [$];
  logic [4:0]  exp_dest [$];
  logic [31:0] exp_data [$];
  logic        accepted;

  rf_write_queue #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dest(wb_dest), .wb_data(wb_data),
    .port_busy(port_busy),
    .rg_wrt_en(rg_wrt_en), .rg_wrt_dest(rg_wrt_dest), .rg_wrt_data(rg_wrt_data),
    .byp_addr1(byp_addr1), .byp_addr2(byp_addr2),
    .byp_hit1(byp_hit1), .byp_data1(byp_data1),
    .byp_hit2(byp_hit2), .byp_data2(byp_data2),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file commits on the falling edge; every commit is logged in order.
  always @(negedge clk) begin
    if (rg_wrt_en) begin
      rf[rg_wrt_dest] = rg_wrt_data;
      log_dest.push_back(rg_wrt_dest);
      log_data.push_back(rg_wrt_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rst = 1'b1; wb_valid = 1'b0; wb_dest = 5'd0; wb_data = 32'h0;
    port_busy = 1'b0; byp_addr1 = 5'd0; byp_addr2 = 5'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(wb_ready), 32'd1);
    check("rst_en",    32'(rg_wrt_en), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_dest",  32'(rg_wrt_dest), 32'd0);
    check("rst_data",  rg_wrt_data, 32'd0);
    check("rst_hit1",  32'(byp_hit1), 32'd0);
    rst = 1'b0;
    step();

    // Single write to r5
    wb_valid = 1'b1; wb_dest = 5'd5; wb_data = 32'hDEADBEEF;
    #1 check("t1_ready", 32'(wb_ready), 32'd1);
    step();
    wb_valid = 1'b0; byp_addr1 = 5'd5;
    #1;
    check("t1_en",    32'(rg_wrt_en), 32'd1);
    check("t1_dest",  32'(rg_wrt_dest), 32'd5);
    check("t1_data",  rg_wrt_data, 32'hDEADBEEF);
    check("t1_count", 32'(count), 32'd1);
    check("t1_hit1",  32'(byp_hit1), 32'd1);
    check("t1_byp1",  byp_data1, 32'hDEADBEEF);
    step();
    check("t1_count0", 32'(count), 32'd0);
    check("t1_en0",    32'(rg_wrt_en), 32'd0);
    check("t1_rf5",    rf[5], 32'hDEADBEEF);
    check("t1_hit1_0", 32'(byp_hit1), 32'd0);
    check("t1_byp1_0", byp_data1, 32'd0);

    // Write to r0 is accepted and dropped
    wb_valid = 1'b1; wb_dest = 5'd0; wb_data = 32'h1234;
    #1 check("t2_ready", 32'(wb_ready), 32'd1);
    step();
    wb_valid = 1'b0;
    #1;
    check("t2_count", 32'(count), 32'd0);
    check("t2_en",    32'(rg_wrt_en), 32'd0);
    step();
    check("t2_en2",   32'(rg_wrt_en), 32'd0);

    // Fill under busy, stall fifth, drain in order
    log_dest.delete(); log_data.delete();
    port_busy = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      wb_valid = 1'b1; wb_dest = 5'(k); wb_data = 32'h100 + 32'(k);
      step();
    end
    wb_dest = 5'd5; wb_data = 32'h105;
    #1;
    check("t3_full_count", 32'(count), 32'd4);
    check("t3_full_ready", 32'(wb_ready), 32'd0);
    check("t3_busy_en",    32'(rg_wrt_en), 32'd0);
    step();
    check("t3_stall_count", 32'(count), 32'd4);
    port_busy = 1'b0;
    #1;
    check("t3_d1_en",    32'(rg_wrt_en), 32'd1);
    check("t3_d1_dest",  32'(rg_wrt_dest), 32'd1);
    check("t3_d1_ready", 32'(wb_ready), 32'd0);
    step();
    check("t3_d2_ready", 32'(wb_ready), 32'd1);
    check("t3_d2_count", 32'(count), 32'd3);
    check("t3_d2_dest",  32'(rg_wrt_dest), 32'd2);
    step();
    wb_valid = 1'b0;
    #1 check("t3_simul_count", 32'(count), 32'd3);
    repeat (3) step();
    check("t3_empty", 32'(count), 32'd0);
    check("t3_log_n", 32'(log_dest.size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < log_dest.size()) begin
        check("t3_log_dest", 32'(log_dest[k]), 32'(k + 1));
        check("t3_log_data", log_data[k], 32'h101 + 32'(k));
      end
    end

    // Bypass: youngest match wins, r0 never hits
    port_busy = 1'b1;
    wb_valid = 1'b1; wb_dest = 5'd7; wb_data = 32'hA; step();
    wb_dest = 5'd7; wb_data = 32'hB; step();
    wb_dest = 5'd3; wb_data = 32'hC; step();
    wb_valid = 1'b0; byp_addr1 = 5'd7; byp_addr2 = 5'd0;
    #1;
    check("t4_hit1",  32'(byp_hit1), 32'd1);
    check("t4_byp1",  byp_data1, 32'hB);
    check("t4_hit2",  32'(byp_hit2), 32'd0);
    check("t4_byp2",  byp_data2, 32'd0);
    byp_addr2 = 5'd3;
    #1;
    check("t4_hit2_r3", 32'(byp_hit2), 32'd1);
    check("t4_byp2_r3", byp_data2, 32'hC);
    byp_addr2 = 5'd9;
    #1;
    check("t4_hit2_miss", 32'(byp_hit2), 32'd0);
    check("t4_byp2_miss", byp_data2, 32'd0);
    port_busy = 1'b0;
    #1;
    check("t4_drain_dest", 32'(rg_wrt_dest), 32'd7);
    check("t4_drain_data", rg_wrt_data, 32'hA);
    check("t4_drain_hit1", 32'(byp_hit1), 32'd1);
    check("t4_drain_byp1", byp_data1, 32'hB);
    repeat (3) step();
    check("t4_empty", 32'(count), 32'd0);
    check("t4_rf7",   rf[7], 32'hB);
    check("t4_rf3",   rf[3], 32'hC);
    check("t4_hit1_0", 32'(byp_hit1), 32'd0);

    // Ten back-to-back writes with alternating busy; pointers wrap
    log_dest.delete(); log_data.delete();
    exp_dest.delete(); exp_data.delete();
    for (int i = 0; i < 10; i++) begin
      wb_valid = 1'b1; wb_dest = 5'(10 + i); wb_data = 32'hC0DE0000 + 32'(i);
      accepted = 1'b0;
      for (int w = 0; w < 16 && !accepted; w++) begin
        #1 accepted = wb_ready;
        step();
        port_busy = ~port_busy;
      end
      check("t5_accept", 32'(accepted), 32'd1);
      exp_dest.push_back(5'(10 + i));
      exp_data.push_back(32'hC0DE0000 + 32'(i));
    end
    wb_valid = 1'b0; port_busy = 1'b0;
    for (int w = 0; w < 20 && count != 3'd0; w++) step();
    check("t5_empty", 32'(count), 32'd0);
    check("t5_log_n", 32'(log_dest.size()), 32'(exp_dest.size()));
    for (int k = 0; k < 10; k++) begin
      if (k < log_dest.size()) begin
        check("t5_log_dest", 32'(log_dest[k]), 32'(exp_dest[k]));
        check("t5_log_data", log_data[k], exp_data[k]);
      end
    end

    // Reset mid-drain discards queued writes
    port_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wb_valid = 1'b1; wb_dest = 5'(20 + k); wb_data = 32'hF00 + 32'(k);
      step();
    end
    wb_valid = 1'b0; byp_addr1 = 5'd20;
    #1 check("t6_count3", 32'(count), 32'd3);
    port_busy = 1'b0;
    #1 check("t6_en_pre", 32'(rg_wrt_en), 32'd1);
    log_dest.delete(); log_data.delete();
    rst = 1'b1;
    #1;
    check("t6_en_rst",    32'(rg_wrt_en), 32'd0);
    check("t6_count_rst", 32'(count), 32'd0);
    check("t6_ready_rst", 32'(wb_ready), 32'd1);
    check("t6_hit1_rst",  32'(byp_hit1), 32'd0);
    step();
    rst = 1'b0;
    repeat (5) step();
    check("t6_no_stale", 32'(log_dest.size()), 32'd0);
    check("t6_en_post",  32'(rg_wrt_en), 32'd0);
    check("t6_rf20",     rf[20], 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
